mem_ref_arbiter: RTL and testbench
==================================

Name: mem_ref_arbiter

Overview:
- Shares the dual-port reference-word memory among NUM_REQ read requesters (seed/extension engines) and one write requester (reference loader).
- Each cycle it grants up to two reads, one per memory port, using two-winner round-robin.
- Writes go through the port-A write path; each read response is routed back to the requester that issued it.
- Sits between the engines and the memory instance, and drives every memory-side control input.

Parameters:
- NUM_REQ, 4, number of read requesters (2..8)
- ADDR_WIDTH, 32, byte address width; memory indexes words as addr>>2
- DATA_WIDTH, 32, reference word width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed byte addresses, requester i at slice i
- req_ready  out  NUM_REQ  grant; handshake = valid&ready in the same cycle
- rsp_valid  out  NUM_REQ  read data valid, one-cycle pulse
- rsp_data  out  NUM_REQ*DATA_WIDTH  packed read data
- wr_valid  in  1  loader write request
- wr_addr  in  ADDR_WIDTH  write byte address
- wr_data  in  DATA_WIDTH  write data
- wr_ready  out  1  write accepted
- mem_addr_A, mem_addr_B  out  ADDR_WIDTH  read addresses to memory
- mem_addw_A, mem_addw_B  out  ADDR_WIDTH  write addresses to memory
- mem_we_A, mem_we_B  out  1  write enables
- mem_din_A, mem_din_B  out  DATA_WIDTH  write data
- mem_dout_A, mem_dout_B  in  DATA_WIDTH  registered read data from memory, valid one cycle after address

Behaviour:
- Reset values:
  - rr_ptr=0; both tag pipeline stages invalid.
  - rsp_valid=0, rsp_data=0.
  - Perf counters (if present) = 0.
- req_ready, wr_ready, mem_* are combinational from the current inputs and registered state.
- Grant selection:
  - Scan requesters from rr_ptr upward, modulo NUM_REQ.
  - First eligible requester goes to port A, second eligible to port B.
  - Eligible = req_valid and not hazard-blocked.
- rr_ptr update on a handshake cycle: (last granted index + 1) mod NUM_REQ. No grant: rr_ptr holds.
- Writes:
  - wr_ready = 1 always; the write path is independent of the read address path.
  - On wr_valid: mem_we_A=1, mem_addw_A=wr_addr, mem_din_A=wr_data.
  - mem_we_B tied 0; mem_addw_B and mem_din_B tied 0.
- Write/read hazard:
  - A requester whose word address (addr>>2) equals wr_addr>>2 while wr_valid=1 is not eligible that cycle (req_ready=0).
  - This removes the cross-port write/read ordering race.
  - The requester is eligible again the next cycle and then reads the new data.
- Idle ports: mem_addr_A/B driven 0 when not granted.
- Tag pipeline: stage0 captures {valid, requester index} per port at the grant edge; stage1 follows one cycle later.
- Latency and response timing:
  - Handshake in cycle T drives the memory address in T.
  - mem_dout is captured at edge T+1.
  - rsp_valid[i] and rsp_data slice i are registered at edge T+2, so they are visible in cycle T+2.
  - Latency is fixed at 2 cycles.
- Throughput:
  - A requester may be granted every cycle; outstanding requests are bounded by the pipeline depth.
  - Responses have no backpressure; requesters must accept them.
- Same requester on both ports in one cycle: not allowed (one grant per requester per cycle).
- Two requesters reading the same address in one cycle: both granted, both receive identical data.
- rsp_data slice i holds its last value when rsp_valid[i]=0.
- Reset mid-operation: in-flight tags are discarded; no rsp_valid pulse after reset is released for requests issued before reset.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- When defined, adds outputs perf_grants (32-bit) and perf_stalls (32-bit).
  - perf_grants increments by the number of reads granted per cycle (0, 1 or 2).
  - perf_stalls increments by 1 on each cycle where any req_valid is not granted.
  - Both counters saturate at all-ones and clear on rst.
- When not defined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - IDX_W = $clog2(NUM_REQ max 8) = 3.
  - typedef rd_tag_t {logic valid; logic [IDX_W-1:0] idx;}.
  - PIPE_LAT = 2.
- Sub-module rr_pick2: combinational two-winner round-robin picker. Inputs: eligible vector and ptr. Outputs: winA/winB valid plus indices.

Test Plan:
- Single request: req0 addr 0x10, memory word 4 = 0xDEADBEEF, handshake at T -> rsp_valid[0] pulses at T+2 with 0xDEADBEEF; no other rsp_valid asserts.
- Full contention: all four requesters valid continuously, rr_ptr=0 -> grants {0,1}, {2,3}, {0,1} on successive cycles; each requester gets one response every 2 cycles, in order.
- Hazard: wr_valid with addr 0x20 / data 0x12345678 while req1 reads 0x20 (old value 0xAAAA5555) -> req_ready[1]=0 that cycle; next-cycle grant returns 0x12345678.
- Same-address dual read: req2 and req3 both read 0x40 -> both granted in the same cycle; both rsp_data slices equal mem[16] at T+2.
- Reset mid-flight: grant req0 at T, assert rst at T+1 -> no rsp_valid at T+2; rr_ptr=0; next grant starts from requester 0.
- Perf (MEM_ARB_PERF_EN): 10 cycles of full contention -> perf_grants=20, perf_stalls=10.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the reference-memory read arbiter
package mem_arb_pkg;

  localparam int IDX_W    = 3;
  localparam int PIPE_LAT = 2;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rd_tag_t;

  // Reduce v (< 2*n) into 0..n-1.
  function automatic logic [IDX_W-1:0] idx_wrap(input logic [IDX_W:0] v, input logic [IDX_W:0] n);
    logic [IDX_W:0] w_r;
    w_r = (v >= n) ? (v - n) : v;
    return w_r[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/mem_ref_arbiter_rr_pick2.sv
// rtl/mem_ref_arbiter_rr_pick2.sv - combinational two-winner round-robin picker
module rr_pick2
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_a_valid,
  output logic [IDX_W-1:0]   o_a_idx,
  output logic               o_b_valid,
  output logic [IDX_W-1:0]   o_b_idx
);

  localparam int MAXR = 1 << IDX_W;

  logic [MAXR-1:0]  w_elig_ext;
  logic [IDX_W-1:0] w_idx;

  assign w_elig_ext = MAXR'(i_elig);

  always_comb begin
    o_a_valid = 1'b0;
    o_a_idx   = '0;
    o_b_valid = 1'b0;
    o_b_idx   = '0;
    w_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = idx_wrap({1'b0, i_ptr} + (IDX_W+1)'(k), (IDX_W+1)'(NUM_REQ));
      if (w_elig_ext[w_idx]) begin
        if (!o_a_valid) begin
          o_a_valid = 1'b1;
          o_a_idx   = w_idx;
        end else if (!o_b_valid) begin
          o_b_valid = 1'b1;
          o_b_idx   = w_idx;
        end
      end
    end
  end

endmodule

// File: rtl/mem_ref_arbiter.sv
// rtl/mem_ref_arbiter.sv - dual-port reference memory arbiter, NUM_REQ readers + one loader writer
// Optional perf counters under MEM_ARB_PERF_EN.
module mem_ref_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  input  logic                          wr_valid,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_ready,
  output logic [ADDR_WIDTH-1:0]         mem_addr_A,
  output logic [ADDR_WIDTH-1:0]         mem_addr_B,
  output logic [ADDR_WIDTH-1:0]         mem_addw_A,
  output logic [ADDR_WIDTH-1:0]         mem_addw_B,
  output logic                          mem_we_A,
  output logic                          mem_we_B,
  output logic [DATA_WIDTH-1:0]         mem_din_A,
  output logic [DATA_WIDTH-1:0]         mem_din_B,
  input  logic [DATA_WIDTH-1:0]         mem_dout_A,
  input  logic [DATA_WIDTH-1:0]         mem_dout_B
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_grants,
  output logic [31:0]                   perf_stalls
`endif
);

  logic [NUM_REQ-1:0]            w_elig;
  logic                          w_a_valid;
  logic [IDX_W-1:0]              w_a_idx;
  logic                          w_b_valid;
  logic [IDX_W-1:0]              w_b_idx;
  logic [IDX_W-1:0]              w_last;
  logic [IDX_W-1:0]              w_next_ptr;
  logic [IDX_W-1:0]              r_rr_ptr;
  rd_tag_t                       r_tag_a [PIPE_LAT];
  rd_tag_t                       r_tag_b [PIPE_LAT];
  logic [NUM_REQ*DATA_WIDTH-1:0] r_rsp_data;

  // A read of the word being written this cycle waits one cycle so it sees the new data.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_valid[i] &&
                  !(wr_valid && (req_addr[i*ADDR_WIDTH+2 +: ADDR_WIDTH-2] == wr_addr[ADDR_WIDTH-1:2]));
    end
  end

  rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_elig    (w_elig),
    .i_ptr     (r_rr_ptr),
    .o_a_valid (w_a_valid),
    .o_a_idx   (w_a_idx),
    .o_b_valid (w_b_valid),
    .o_b_idx   (w_b_idx)
  );

  always_comb begin
    req_ready  = '0;
    mem_addr_A = '0;
    mem_addr_B = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_a_valid && (w_a_idx == IDX_W'(i))) begin
        req_ready[i] = 1'b1;
        mem_addr_A   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (w_b_valid && (w_b_idx == IDX_W'(i))) begin
        req_ready[i] = 1'b1;
        mem_addr_B   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign wr_ready   = 1'b1;
  assign mem_we_A   = wr_valid;
  assign mem_addw_A = wr_valid ? wr_addr : '0;
  assign mem_din_A  = wr_valid ? wr_data : '0;
  assign mem_we_B   = 1'b0;
  assign mem_addw_B = '0;
  assign mem_din_B  = '0;

  assign w_last     = w_b_valid ? w_b_idx : w_a_idx;
  assign w_next_ptr = idx_wrap({1'b0, w_last} + (IDX_W+1)'(1), (IDX_W+1)'(NUM_REQ));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      for (int s = 0; s < PIPE_LAT; s++) begin
        r_tag_a[s] <= '0;
        r_tag_b[s] <= '0;
      end
    end else begin
      if (w_a_valid) begin
        r_rr_ptr <= w_next_ptr;
      end
      r_tag_a[0] <= '{valid: w_a_valid, idx: w_a_idx};
      r_tag_b[0] <= '{valid: w_b_valid, idx: w_b_idx};
      for (int s = 1; s < PIPE_LAT; s++) begin
        r_tag_a[s] <= r_tag_a[s-1];
        r_tag_b[s] <= r_tag_b[s-1];
      end
    end
  end

  // Memory data is valid while stage 0 holds its tag; the data lands with stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_data <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_tag_a[0].valid && (r_tag_a[0].idx == IDX_W'(i))) begin
          r_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] <= mem_dout_A;
        end else if (r_tag_b[0].valid && (r_tag_b[0].idx == IDX_W'(i))) begin
          r_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] <= mem_dout_B;
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (r_tag_a[PIPE_LAT-1].valid && (r_tag_a[PIPE_LAT-1].idx == IDX_W'(i))) ||
                     (r_tag_b[PIPE_LAT-1].valid && (r_tag_b[PIPE_LAT-1].idx == IDX_W'(i)));
    end
  end

  assign rsp_data = r_rsp_data;

`ifdef MEM_ARB_PERF_EN
  logic [1:0]  w_ngrant;
  logic [32:0] w_grant_sum;
  logic [32:0] w_stall_sum;
  logic        w_stall;
  logic [31:0] r_perf_grants;
  logic [31:0] r_perf_stalls;

  assign w_ngrant    = {1'b0, w_a_valid} + {1'b0, w_b_valid};
  assign w_stall     = |(req_valid & ~req_ready);
  assign w_grant_sum = {1'b0, r_perf_grants} + 33'(w_ngrant);
  assign w_stall_sum = {1'b0, r_perf_stalls} + 33'(w_stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_grants <= '0;
      r_perf_stalls <= '0;
    end else begin
      r_perf_grants <= w_grant_sum[32] ? '1 : w_grant_sum[31:0];
      r_perf_stalls <= w_stall_sum[32] ? '1 : w_stall_sum[31:0];
    end
  end

  assign perf_grants = r_perf_grants;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_mem_ref_arbiter.sv
// tb/tb_mem_ref_arbiter.sv - table-driven bench for mem_ref_arbiter with a behavioural dual-port memory
module tb_mem_ref_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_data;
  logic            wr_valid;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            wr_ready;
  logic [AW-1:0]   mem_addr_A, mem_addr_B, mem_addw_A, mem_addw_B;
  logic            mem_we_A, mem_we_B;
  logic [DW-1:0]   mem_din_A, mem_din_B, mem_dout_A, mem_dout_B;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]     perf_grants, perf_stalls;
`endif

  int checks = 0;
  int errors = 0;

  mem_ref_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .mem_addr_A (mem_addr_A),
    .mem_addr_B (mem_addr_B),
    .mem_addw_A (mem_addw_A),
    .mem_addw_B (mem_addw_B),
    .mem_we_A   (mem_we_A),
    .mem_we_B   (mem_we_B),
    .mem_din_A  (mem_din_A),
    .mem_din_B  (mem_din_B),
    .mem_dout_A (mem_dout_A),
    .mem_dout_B (mem_dout_B)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_grants(perf_grants),
    .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Registered-read dual-port memory; contents reload while rst is high.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
      mem[4]  <= 32'hDEAD_BEEF;
      mem[8]  <= 32'hAAAA_5555;
      mem[16] <= 32'hC0FF_EE16;
    end else if (mem_we_A) begin
      mem[mem_addw_A[9:2]] <= mem_din_A;
    end
    mem_dout_A <= mem[mem_addr_A[9:2]];
    mem_dout_B <= mem[mem_addr_B[9:2]];
  end

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] a3;
    logic        wv;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  ready;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [3:0]  rspv;
    logic [31:0] d [4];
  } vec_t;

  vec_t tbl [$];

  task automatic row(input logic [3:0] rv, input logic [31:0] a3, input logic wv,
                     input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ready,
                     input logic [31:0] ma, input logic [31:0] mb, input logic [3:0] rspv,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                     input logic [31:0] d3);
    vec_t v;
    v.rv = rv; v.a3 = a3; v.wv = wv; v.wa = wa; v.wd = wd;
    v.ready = ready; v.ma = ma; v.mb = mb; v.rspv = rspv;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rv, input logic [31:0] a3, input logic wv,
                       input logic [31:0] wa, input logic [31:0] wd);
    req_valid = rv;
    req_addr  = {a3, 32'h40, 32'h20, 32'h10};
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
  endtask

  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] A5 = 32'hAAAA_5555;
  localparam logic [31:0] CF = 32'hC0FF_EE16;
  localparam logic [31:0] M17 = 32'hA000_0011;
  localparam logic [31:0] NW = 32'h1234_5678;

  initial begin
    //   rv    a3     wv wa     wd  ready ma     mb     rspv d0  d1  d2  d3
    row(4'hF, 32'h44, 0, 32'h0, 0, 4'h3, 32'h10, 32'h20, 4'h0, 0,  0,  0,  0);
    row(4'hF, 32'h44, 0, 32'h0, 0, 4'hC, 32'h40, 32'h44, 4'h0, 0,  0,  0,  0);
    row(4'hF, 32'h44, 0, 32'h0, 0, 4'h3, 32'h10, 32'h20, 4'h3, DB, A5, 0,  0);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'hC, 0,  0,  CF, M17);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'h3, DB, A5, 0,  0);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'h0, 0,  0,  0,  0);
    row(4'h1, 32'h44, 0, 32'h0, 0, 4'h1, 32'h10, 32'h0,  4'h0, 0,  0,  0,  0);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'h0, 0,  0,  0,  0);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'h1, DB, 0,  0,  0);
    row(4'h3, 32'h44, 1, 32'h20, NW, 4'h1, 32'h10, 32'h0, 4'h0, 0,  0,  0,  0);
    row(4'h2, 32'h44, 0, 32'h0, 0, 4'h2, 32'h20, 32'h0,  4'h0, 0,  0,  0,  0);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'h1, DB, 0,  0,  0);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'h2, 0,  NW, 0,  0);
    row(4'hC, 32'h40, 0, 32'h0, 0, 4'hC, 32'h40, 32'h40, 4'h0, 0,  0,  0,  0);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'h0, 0,  0,  0,  0);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'hC, 0,  0,  CF, CF);
    row(4'h9, 32'h44, 0, 32'h0, 0, 4'h9, 32'h10, 32'h44, 4'h0, 0,  0,  0,  0);
    row(4'h9, 32'h44, 0, 32'h0, 0, 4'h9, 32'h10, 32'h44, 4'h0, 0,  0,  0,  0);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'h9, DB, 0,  0,  M17);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'h9, DB, 0,  0,  M17);
    row(4'h4, 32'h44, 0, 32'h0, 0, 4'h4, 32'h40, 32'h0,  4'h0, 0,  0,  0,  0);
    row(4'h5, 32'h44, 0, 32'h0, 0, 4'h5, 32'h10, 32'h40, 4'h0, 0,  0,  0,  0);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'h4, 0,  0,  CF, 0);
    row(4'h0, 32'h44, 0, 32'h0, 0, 4'h0, 32'h0,  32'h0,  4'h5, DB, 0,  CF, 0);

    rst = 1'b1;
    drive(4'h0, 32'h44, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_data", rsp_data[31:0] | rsp_data[63:32] | rsp_data[95:64] | rsp_data[127:96], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int c = 0; c < tbl.size(); c++) begin
      drive(tbl[c].rv, tbl[c].a3, tbl[c].wv, tbl[c].wa, tbl[c].wd);
      @(negedge clk);
      chk($sformatf("row%0d req_ready", c), 32'(req_ready), 32'(tbl[c].ready));
      chk($sformatf("row%0d mem_addr_A", c), mem_addr_A, tbl[c].ma);
      chk($sformatf("row%0d mem_addr_B", c), mem_addr_B, tbl[c].mb);
      chk($sformatf("row%0d rsp_valid", c), 32'(rsp_valid), 32'(tbl[c].rspv));
      chk($sformatf("row%0d write path", c),
          {mem_addw_A[29:0], mem_we_A, mem_we_B | ~wr_ready},
          {(tbl[c].wv ? tbl[c].wa[29:0] : 30'h0), tbl[c].wv, 1'b0});
      if (tbl[c].wv) chk($sformatf("row%0d mem_din_A", c), mem_din_A, tbl[c].wd);
      for (int i = 0; i < N; i++) begin
        if (tbl[c].rspv[i]) chk($sformatf("row%0d rsp_data%0d", c, i), rsp_data[i*DW +: DW], tbl[c].d[i]);
      end
      @(posedge clk); #1;
    end

    // Reset while a read is in flight: the response must be dropped and the pointer restart at 0.
    drive(4'h1, 32'h44, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("midrst grant req0", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(4'h0, 32'h44, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'hF, 32'h44, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("midrst no rsp", 32'(rsp_valid), 32'h0);
    chk("midrst ptr restart", 32'(req_ready), 32'h3);
    @(posedge clk); #1;
    drive(4'h0, 32'h44, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("midrst idle rsp", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst rsp_valid", 32'(rsp_valid), 32'h3);
    chk("postrst rsp_data0", rsp_data[31:0], DB);
    chk("postrst rsp_data1", rsp_data[63:32], A5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("postrst hold data0", rsp_data[31:0], DB);
    chk("postrst single pulse", 32'(rsp_valid), 32'h0);

`ifdef MEM_ARB_PERF_EN
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'hF, 32'h44, 1'b0, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    drive(4'h0, 32'h44, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("perf_grants", perf_grants, 32'd20);
    chk("perf_stalls", perf_stalls, 32'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
